// File: rtl/active_list.sv
// active_list: in-order tracking of renamed instructions; commits from the head,
// rolls back youngest-first on flush so rename can restore its map and free list.
module active_list #(
    parameter int DEPTH  = 16,
    parameter int PREG_W = 6,
    parameter int AREG_W = 5,
    localparam int TAG_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_valid_i,
    output logic              alloc_ready_o,
    input  logic              alloc_has_dest_i,
    input  logic [AREG_W-1:0] alloc_areg_i,
    input  logic [PREG_W-1:0] alloc_new_preg_i,
    input  logic [PREG_W-1:0] alloc_old_preg_i,
    output logic [TAG_W-1:0]  alloc_tag_o,
    input  logic              wb_valid_i,
    input  logic [TAG_W-1:0]  wb_tag_i,
    output logic              commit_valid_o,
    input  logic              commit_ready_i,
    output logic              commit_has_dest_o,
    output logic [AREG_W-1:0] commit_areg_o,
    output logic [PREG_W-1:0] commit_free_preg_o,
    input  logic              flush_i,
    output logic              rb_valid_o,
    output logic              rb_has_dest_o,
    output logic [AREG_W-1:0] rb_areg_o,
    output logic [PREG_W-1:0] rb_old_preg_o,
    output logic [PREG_W-1:0] rb_new_preg_o,
    output logic              rb_done_o,
    output logic [TAG_W:0]    count_o,
    output logic              empty_o,
    output logic              full_o
);
    typedef enum logic {RUN, ROLLBACK} state_t;

    state_t              state_q, state_d;
    logic [TAG_W-1:0]    head_q, head_d, tail_q, tail_d, tail_m1, wb_off;
    logic [TAG_W:0]      count_q, count_d;
    logic [DEPTH-1:0]    done_q, done_d;
    logic                rb_done_q, rb_done_d;
    logic                has_dest_q [DEPTH];
    logic [AREG_W-1:0]   areg_q     [DEPTH];
    logic [PREG_W-1:0]   new_preg_q [DEPTH];
    logic [PREG_W-1:0]   old_preg_q [DEPTH];
    logic                run, alloc_fire, commit_fire, wb_hit;

    assign run         = state_q == RUN;
    assign tail_m1     = tail_q - TAG_W'(1);
    assign wb_off      = wb_tag_i - head_q;
    assign empty_o     = count_q == '0;
    assign full_o      = count_q == (TAG_W+1)'(DEPTH);
    assign count_o     = count_q;
    assign alloc_tag_o = tail_q;
    assign rb_done_o   = rb_done_q;
    assign alloc_fire  = alloc_valid_i && alloc_ready_o;
    assign commit_fire = commit_valid_o && commit_ready_i;
    // Occupancy is judged by distance from head, so stale or free slots never get marked done
    assign wb_hit      = run && wb_valid_i && ({1'b0, wb_off} < count_q);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;

    always_comb begin
        state_d = state_q;
        if (run && flush_i && !empty_o)
            state_d = ROLLBACK;
        else if (!run && count_q == (TAG_W+1)'(1))
            state_d = RUN;
    end

    always_comb begin
        alloc_ready_o      = run && !full_o && !flush_i;
        commit_valid_o     = run && !empty_o && done_q[head_q] && !flush_i;
        rb_valid_o         = !run;
        commit_has_dest_o  = commit_valid_o && has_dest_q[head_q];
        commit_areg_o      = commit_valid_o ? areg_q[head_q] : '0;
        commit_free_preg_o = commit_valid_o ? old_preg_q[head_q] : '0;
        rb_has_dest_o      = rb_valid_o && has_dest_q[tail_m1];
        rb_areg_o          = rb_valid_o ? areg_q[tail_m1] : '0;
        rb_old_preg_o      = rb_valid_o ? old_preg_q[tail_m1] : '0;
        rb_new_preg_o      = rb_valid_o ? new_preg_q[tail_m1] : '0;
    end

    always_comb begin
        head_d    = head_q + TAG_W'(commit_fire);
        tail_d    = rb_valid_o ? tail_m1 : tail_q + TAG_W'(alloc_fire);
        count_d   = rb_valid_o ? count_q - (TAG_W+1)'(1)
                               : count_q + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(commit_fire);
        rb_done_d = run ? flush_i && empty_o : count_q == (TAG_W+1)'(1);
        done_d    = done_q;
        if (wb_hit)      done_d[wb_tag_i] = 1'b1;
        if (alloc_fire)  done_d[tail_q]   = 1'b0;
        if (commit_fire) done_d[head_q]   = 1'b0;
        if (rb_valid_o)  done_d[tail_m1]  = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            done_q    <= '0;
            rb_done_q <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            done_q    <= done_d;
            rb_done_q <= rb_done_d;
        end

    always_ff @(posedge clk)
        if (alloc_fire) begin
            has_dest_q[tail_q] <= alloc_has_dest_i;
            areg_q[tail_q]     <= alloc_areg_i;
            new_preg_q[tail_q] <= alloc_new_preg_i;
            old_preg_q[tail_q] <= alloc_old_preg_i;
        end
endmodule

// File: tb/tb_active_list.sv
// tb_active_list: scoreboard bench; allocations push expected commit and rollback
// records, a negedge monitor pops and compares them as the DUT presents them.
module tb_active_list;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       alloc_valid_i = 0, alloc_ready_o, alloc_has_dest_i = 0;
    logic [4:0] alloc_areg_i = 0;
    logic [5:0] alloc_new_preg_i = 0, alloc_old_preg_i = 0;
    logic [3:0] alloc_tag_o, wb_tag_i = 0;
    logic       wb_valid_i = 0, commit_valid_o, commit_ready_i = 0, commit_has_dest_o;
    logic [4:0] commit_areg_o, rb_areg_o;
    logic [5:0] commit_free_preg_o, rb_old_preg_o, rb_new_preg_o;
    logic       flush_i = 0, rb_valid_o, rb_has_dest_o, rb_done_o, empty_o, full_o;
    logic [4:0] count_o;

    always #5 clk = ~clk;

    active_list dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
        .alloc_has_dest_i(alloc_has_dest_i), .alloc_areg_i(alloc_areg_i),
        .alloc_new_preg_i(alloc_new_preg_i), .alloc_old_preg_i(alloc_old_preg_i),
        .alloc_tag_o(alloc_tag_o), .wb_valid_i(wb_valid_i), .wb_tag_i(wb_tag_i),
        .commit_valid_o(commit_valid_o), .commit_ready_i(commit_ready_i),
        .commit_has_dest_o(commit_has_dest_o), .commit_areg_o(commit_areg_o),
        .commit_free_preg_o(commit_free_preg_o), .flush_i(flush_i),
        .rb_valid_o(rb_valid_o), .rb_has_dest_o(rb_has_dest_o), .rb_areg_o(rb_areg_o),
        .rb_old_preg_o(rb_old_preg_o), .rb_new_preg_o(rb_new_preg_o),
        .rb_done_o(rb_done_o), .count_o(count_o), .empty_o(empty_o), .full_o(full_o)
    );

    typedef struct { int hd; int areg; int newp; int oldp; } rec_t;
    rec_t cq[$], rq[$];
    int tests = 0, fails = 0, rb_seen = 0, commits_seen = 0;

    task automatic chk(input string n, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", n, got, exp);
        end
    endtask

    always @(negedge clk) begin
        rec_t r;
        if (rst_n) begin
            if (commit_valid_o && rb_valid_o) chk("commit_rb_exclusive", 1, 0);
            if (commit_valid_o && commit_ready_i) begin
                commits_seen++;
                if (cq.size() == 0) chk("commit_unexpected", 1, 0);
                else begin
                    r = cq.pop_front();
                    chk("commit_has_dest", int'(commit_has_dest_o), r.hd);
                    chk("commit_areg", int'(commit_areg_o), r.areg);
                    chk("commit_free_preg", int'(commit_free_preg_o), r.oldp);
                end
            end
            if (rb_valid_o) begin
                rb_seen++;
                if (rq.size() == 0) chk("rb_unexpected", 1, 0);
                else begin
                    r = rq.pop_front();
                    chk("rb_has_dest", int'(rb_has_dest_o), r.hd);
                    chk("rb_areg", int'(rb_areg_o), r.areg);
                    chk("rb_old_preg", int'(rb_old_preg_o), r.oldp);
                    chk("rb_new_preg", int'(rb_new_preg_o), r.newp);
                end
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_alloc(input int a);
        alloc_valid_i    = 1'b1;
        alloc_has_dest_i = a != 0;
        alloc_areg_i     = a[4:0];
        alloc_new_preg_i = 6'(31 + a);
        alloc_old_preg_i = a[5:0];
    endtask

    task automatic alloc(input int a, input int exp_tag);
        rec_t r;
        set_alloc(a);
        chk("alloc_ready", int'(alloc_ready_o), 1);
        chk("alloc_tag", int'(alloc_tag_o), exp_tag);
        r = '{int'(a != 0), a, 31 + a, a};
        cq.push_back(r);
        rq.push_front(r);
        step;
        alloc_valid_i = 1'b0;
    endtask

    task automatic wb(input int t);
        wb_valid_i = 1'b1;
        wb_tag_i   = 4'(t);
        step;
        wb_valid_i = 1'b0;
    endtask

    task automatic drain;
        for (int i = 0; i < 40 && count_o != 0; i++) step;
        chk("drain_count", int'(count_o), 0);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        {alloc_valid_i, wb_valid_i, commit_ready_i, flush_i} = '0;
        cq.delete();
        rq.delete();
        step;
        step;
        rst_n = 1'b1;
    endtask

    initial begin
        int c0, s0;
        step;
        step;
        chk("rst_count", int'(count_o), 0);
        chk("rst_empty", int'(empty_o), 1);
        chk("rst_full", int'(full_o), 0);
        chk("rst_alloc_ready", int'(alloc_ready_o), 1);
        chk("rst_commit_valid", int'(commit_valid_o), 0);
        chk("rst_rb_valid", int'(rb_valid_o), 0);
        chk("rst_rb_done", int'(rb_done_o), 0);
        chk("rst_commit_areg", int'(commit_areg_o), 0);
        rst_n = 1'b1;

        // in-order basic flow
        for (int i = 1; i <= 3; i++) alloc(i, i - 1);
        chk("t1_count3", int'(count_o), 3);
        for (int i = 0; i < 3; i++) wb(i);
        c0 = commits_seen;
        commit_ready_i = 1'b1;
        drain;
        chk("t1_commits", commits_seen - c0, 3);

        // out-of-order write-back: tags 3,4,5 completed 5,3,4
        for (int i = 4; i <= 6; i++) alloc(i, i - 1);
        wb(5);
        chk("t2_no_commit_yet", int'(commit_valid_o), 0);
        wb(3);
        chk("t2_head_ready", int'(commit_valid_o), 1);
        wb(4);
        drain;
        chk("t2_queue_empty", cq.size(), 0);

        // full, blocked alloc during commit, wrap to tag 0
        do_reset;
        for (int i = 0; i < 16; i++) alloc(i, i);
        chk("t3_full", int'(full_o), 1);
        chk("t3_full_ready", int'(alloc_ready_o), 0);
        chk("t3_count16", int'(count_o), 16);
        wb(0);
        commit_ready_i = 1'b1;
        set_alloc(20);
        chk("t3_commit_valid", int'(commit_valid_o), 1);
        chk("t3_blocked", int'(alloc_ready_o), 0);
        step;
        commit_ready_i = 1'b0;
        chk("t3_count15", int'(count_o), 15);
        alloc(20, 0);
        chk("t3_refull", int'(full_o), 1);

        // flush with 5 entries, inputs ignored during rollback
        do_reset;
        for (int i = 1; i <= 5; i++) alloc(i, i - 1);
        s0 = rb_seen;
        flush_i = 1'b1;
        step;
        chk("t4_rb_valid", int'(rb_valid_o), 1);
        chk("t4_rb_alloc_ready", int'(alloc_ready_o), 0);
        set_alloc(25);
        wb_valid_i = 1'b1;
        wb_tag_i = 4'd0;
        commit_ready_i = 1'b1;
        step;
        step;
        {alloc_valid_i, wb_valid_i, commit_ready_i, flush_i} = '0;
        for (int i = 0; i < 20 && !rb_done_o; i++) step;
        chk("t4_rb_done", int'(rb_done_o), 1);
        chk("t4_count0", int'(count_o), 0);
        chk("t4_rb_cycles", rb_seen - s0, 5);
        chk("t4_rq_empty", rq.size(), 0);
        step;
        chk("t4_rb_done_pulse", int'(rb_done_o), 0);
        alloc(9, 0);

        // flush on empty list
        do_reset;
        s0 = rb_seen;
        flush_i = 1'b1;
        step;
        flush_i = 1'b0;
        chk("t5_rb_done", int'(rb_done_o), 1);
        chk("t5_rb_valid", int'(rb_valid_o), 0);
        step;
        chk("t5_rb_done_pulse", int'(rb_done_o), 0);
        chk("t5_no_rb", rb_seen - s0, 0);

        // asynchronous reset mid-rollback
        do_reset;
        for (int i = 1; i <= 4; i++) alloc(i, i - 1);
        flush_i = 1'b1;
        step;
        flush_i = 1'b0;
        step;
        chk("t6_in_rb", int'(rb_valid_o), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rb_valid", int'(rb_valid_o), 0);
        chk("t6_count", int'(count_o), 0);
        chk("t6_empty", int'(empty_o), 1);
        chk("t6_alloc_ready", int'(alloc_ready_o), 1);
        rq.delete();
        cq.delete();
        step;
        rst_n = 1'b1;
        step;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
